// File: rtl/preg_alloc_ctrl.sv
// Physical-register free-list controller: 2-wide allocate, 2-wide free, per-tag head checkpoints.
// Optional build macro PREG_ALLOC_STATS_EN adds stall_cycles / alloc_count counters.
module preg_alloc_ctrl #(
  parameter int NUM_PREGS              = 64,
  parameter int NUM_AREGS              = 32,
  parameter int MAX_PREDICT_DEPTH_BITS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        alloc_req,
  output logic                              alloc_grant,
  output logic [$clog2(NUM_PREGS)-1:0]      preg1,
  output logic [$clog2(NUM_PREGS)-1:0]      preg2,
  output logic [$clog2(NUM_PREGS):0]        num_free,
  input  logic                              free_valid_1,
  input  logic [$clog2(NUM_PREGS)-1:0]      free_preg_1,
  input  logic                              free_valid_2,
  input  logic [$clog2(NUM_PREGS)-1:0]      free_preg_2,
  input  logic                              ckpt_valid,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] ckpt_tag,
  input  logic                              shootdown,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_tag
`ifdef PREG_ALLOC_STATS_EN
  ,
  output logic [31:0]                       stall_cycles,
  output logic [31:0]                       alloc_count
`endif
);

  localparam int PW    = $clog2(NUM_PREGS);
  localparam int NT    = 1 << MAX_PREDICT_DEPTH_BITS;
  localparam int NINIT = NUM_PREGS - NUM_AREGS;
  localparam logic [PW:0] INIT_FREE = NINIT[PW:0];

  logic [PW-1:0] fl   [NUM_PREGS];
  logic [PW:0]   ckpt [NT];
  logic [PW:0]   head;
  logic [PW:0]   tail;
  logic [PW:0]   num_free_q;

  logic [1:0]    req_eff;
  logic [PW:0]   req_ext;
  logic [PW:0]   free_cnt;
  logic [PW:0]   head_alloc;
  logic [PW:0]   head_next;
  logic [PW:0]   tail_next;
  logic [PW:0]   nf_next;
  logic [PW-1:0] head_idx1;
  logic [PW-1:0] tail_idx2;

  // Handshake: rename drives alloc_req (a count, 0..2) every cycle; the pregs on
  // preg1/preg2 are consumed only in a cycle where alloc_grant is 1. With
  // alloc_grant 0 nothing is taken and rename must hold the request and retry.
  always_comb begin
    req_eff     = (alloc_req == 2'd3) ? 2'd0 : alloc_req;
    req_ext     = {{(PW-1){1'b0}}, req_eff};
    alloc_grant = reset && !shootdown && (req_ext <= num_free_q);
    free_cnt    = {{(PW-1){1'b0}}, ({1'b0, free_valid_1} + {1'b0, free_valid_2})};
    head_alloc  = alloc_grant ? (head + req_ext) : head;
    head_next   = shootdown ? ckpt[shootdown_tag] : head_alloc;
    tail_next   = tail + free_cnt;
    nf_next     = tail_next - head_next;
    head_idx1   = head[PW-1:0] + PW'(1);
    // Second free lands behind the first only when the first is valid.
    tail_idx2   = tail[PW-1:0] + (free_valid_1 ? PW'(1) : PW'(0));
  end

  assign preg1    = fl[head[PW-1:0]];
  assign preg2    = fl[head_idx1];
  assign num_free = num_free_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        fl[i] <= (i < NINIT) ? PW'(NUM_AREGS + i) : '0;
      end
      for (int t = 0; t < NT; t++) begin
        ckpt[t] <= '0;
      end
      head       <= '0;
      tail       <= INIT_FREE;
      num_free_q <= INIT_FREE;
    end else begin
      if (free_valid_1) fl[tail[PW-1:0]] <= free_preg_1;
      if (free_valid_2) fl[tail_idx2]    <= free_preg_2;
      head       <= head_next;
      tail       <= tail_next;
      num_free_q <= nf_next;
      if (ckpt_valid && !shootdown) ckpt[ckpt_tag] <= head_alloc;
    end
  end

`ifdef PREG_ALLOC_STATS_EN
  logic [32:0] alloc_sum;
  assign alloc_sum = {1'b0, alloc_count} + {31'd0, req_eff};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      alloc_count  <= '0;
    end else begin
      if ((req_eff != 2'd0) && !alloc_grant && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (alloc_grant)
        alloc_count <= alloc_sum[32] ? 32'hFFFF_FFFF : alloc_sum[31:0];
    end
  end
`endif

`ifndef SYNTHESIS
  // Commit freeing more than it owes, or rename asking for 3, is an upstream bug.
  always @(posedge clk) begin
    if (reset) begin
      assert (alloc_req != 2'd3) else $error("preg_alloc_ctrl: illegal alloc_req=3");
      assert (nf_next <= INIT_FREE) else $error("preg_alloc_ctrl: free list overflow");
    end
  end
`endif

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Bench for preg_alloc_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_preg_alloc_ctrl;
  localparam int PW = 6;
  localparam int MD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    alloc_req;
  logic          alloc_grant;
  logic [PW-1:0] preg1, preg2;
  logic [PW:0]   num_free;
  logic          free_valid_1, free_valid_2;
  logic [PW-1:0] free_preg_1, free_preg_2;
  logic          ckpt_valid;
  logic [MD-1:0] ckpt_tag;
  logic          shootdown;
  logic [MD-1:0] shootdown_tag;
`ifdef PREG_ALLOC_STATS_EN
  logic [31:0]   stall_cycles, alloc_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Free-list model: exp_q holds free pregs in allocation order; pool holds pregs
  // that are in use and may legally be freed by commit.
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] pool[$];

  preg_alloc_ctrl dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_grant(alloc_grant),
    .preg1(preg1), .preg2(preg2), .num_free(num_free),
    .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
    .free_valid_2(free_valid_2), .free_preg_2(free_preg_2),
    .ckpt_valid(ckpt_valid), .ckpt_tag(ckpt_tag),
    .shootdown(shootdown), .shootdown_tag(shootdown_tag)
`ifdef PREG_ALLOC_STATS_EN
    , .stall_cycles(stall_cycles), .alloc_count(alloc_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alloc_req = 2'd0; free_valid_1 = 1'b0; free_preg_1 = '0;
    free_valid_2 = 1'b0; free_preg_2 = '0; ckpt_valid = 1'b0; ckpt_tag = '0;
    shootdown = 1'b0; shootdown_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0; #2; reset = 1'b1;
    tick();
  endtask

  task automatic alloc_cycles(input int n, input logic [1:0] req);
    for (int i = 0; i < n; i++) begin
      alloc_req = req; tick();
    end
    alloc_req = 2'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; alloc_req = 2'd2; #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", alloc_grant); end
    checks++; if (num_free !== 7'd32) begin failures++; $display("FAIL reset_num_free got=%0d exp=32", num_free); end
    alloc_req = 2'd0; reset = 1'b1; #1;
    checks++; if (preg1 !== 6'd32) begin failures++; $display("FAIL reset_preg1 got=%0d exp=32", preg1); end
    checks++; if (preg2 !== 6'd33) begin failures++; $display("FAIL reset_preg2 got=%0d exp=33", preg2); end
    alloc_req = 2'd2; #1;
    checks++; if (alloc_grant !== 1'b1) begin failures++; $display("FAIL first_grant got=%0d exp=1", alloc_grant); end
    tick(); alloc_req = 2'd0; #1;
    checks++; if (preg1 !== 6'd34) begin failures++; $display("FAIL first_preg1 got=%0d exp=34", preg1); end
    checks++; if (preg2 !== 6'd35) begin failures++; $display("FAIL first_preg2 got=%0d exp=35", preg2); end
    checks++; if (num_free !== 7'd30) begin failures++; $display("FAIL first_num_free got=%0d exp=30", num_free); end
  endtask

  task automatic test_exhaust();
    alloc_cycles(14, 2'd2);
    alloc_cycles(1, 2'd1);
    #1;
    checks++; if (num_free !== 7'd1) begin failures++; $display("FAIL exh_num_free got=%0d exp=1", num_free); end
    checks++; if (preg1 !== 6'd63) begin failures++; $display("FAIL exh_preg1 got=%0d exp=63", preg1); end
    alloc_req = 2'd2; #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL exh_deny got=%0d exp=0", alloc_grant); end
    tick(); #1;
    checks++; if (num_free !== 7'd1) begin failures++; $display("FAIL exh_hold_nf got=%0d exp=1", num_free); end
    checks++; if (preg1 !== 6'd63) begin failures++; $display("FAIL exh_hold_preg1 got=%0d exp=63", preg1); end
    alloc_req = 2'd1; #1;
    checks++; if (alloc_grant !== 1'b1) begin failures++; $display("FAIL exh_last_grant got=%0d exp=1", alloc_grant); end
    tick(); alloc_req = 2'd0; #1;
    checks++; if (num_free !== 7'd0) begin failures++; $display("FAIL exh_empty_nf got=%0d exp=0", num_free); end
    checks++; if (alloc_grant !== 1'b1) begin failures++; $display("FAIL exh_req0_grant got=%0d exp=1", alloc_grant); end
  endtask

  task automatic test_empty_free();
    alloc_req = 2'd2;
    free_valid_1 = 1'b1; free_preg_1 = 6'd5;
    free_valid_2 = 1'b1; free_preg_2 = 6'd9; #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL empty_free_grant got=%0d exp=0", alloc_grant); end
    tick(); clear_inputs(); #1;
    checks++; if (num_free !== 7'd2) begin failures++; $display("FAIL empty_free_nf got=%0d exp=2", num_free); end
    checks++; if (preg1 !== 6'd5) begin failures++; $display("FAIL empty_free_preg1 got=%0d exp=5", preg1); end
    checks++; if (preg2 !== 6'd9) begin failures++; $display("FAIL empty_free_preg2 got=%0d exp=9", preg2); end
  endtask

  task automatic test_ckpt_shootdown();
    do_reset();
    alloc_cycles(2, 2'd2);
    alloc_req = 2'd2; ckpt_valid = 1'b1; ckpt_tag = 2'd3;
    tick(); clear_inputs();
    alloc_cycles(3, 2'd2);
    #1;
    checks++; if (num_free !== 7'd20) begin failures++; $display("FAIL ckpt_pre_nf got=%0d exp=20", num_free); end
    shootdown = 1'b1; shootdown_tag = 2'd3; alloc_req = 2'd2; #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL sd_grant got=%0d exp=0", alloc_grant); end
    tick(); clear_inputs(); #1;
    checks++; if (num_free !== 7'd26) begin failures++; $display("FAIL sd_nf got=%0d exp=26", num_free); end
    checks++; if (preg1 !== 6'd38) begin failures++; $display("FAIL sd_preg1 got=%0d exp=38", preg1); end
    checks++; if (preg2 !== 6'd39) begin failures++; $display("FAIL sd_preg2 got=%0d exp=39", preg2); end
  endtask

  task automatic test_shootdown_free();
    ckpt_valid = 1'b1; ckpt_tag = 2'd1;
    tick(); clear_inputs();
    alloc_cycles(1, 2'd2);
    #1;
    checks++; if (preg1 !== 6'd40) begin failures++; $display("FAIL sdf_pre_preg1 got=%0d exp=40", preg1); end
    shootdown = 1'b1; shootdown_tag = 2'd1; alloc_req = 2'd2;
    free_valid_1 = 1'b1; free_preg_1 = 6'd7; #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL sdf_grant got=%0d exp=0", alloc_grant); end
    tick(); clear_inputs(); #1;
    checks++; if (num_free !== 7'd27) begin failures++; $display("FAIL sdf_nf got=%0d exp=27", num_free); end
    checks++; if (preg1 !== 6'd38) begin failures++; $display("FAIL sdf_preg1 got=%0d exp=38", preg1); end
    alloc_cycles(13, 2'd2);
    #1;
    checks++; if (num_free !== 7'd1) begin failures++; $display("FAIL sdf_tail_nf got=%0d exp=1", num_free); end
    checks++; if (preg1 !== 6'd7) begin failures++; $display("FAIL sdf_tail_preg1 got=%0d exp=7", preg1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_cycles(5, 2'd2);
    alloc_req = 2'd2; #1;
    checks++; if (num_free !== 7'd22) begin failures++; $display("FAIL mid_pre_nf got=%0d exp=22", num_free); end
    #2; reset = 1'b0; #1;
    checks++; if (num_free !== 7'd32) begin failures++; $display("FAIL mid_nf got=%0d exp=32", num_free); end
    checks++; if (preg1 !== 6'd32) begin failures++; $display("FAIL mid_preg1 got=%0d exp=32", preg1); end
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL mid_grant got=%0d exp=0", alloc_grant); end
    alloc_req = 2'd0; reset = 1'b1;
    tick();
`ifdef PREG_ALLOC_STATS_EN
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL mid_stall0 got=%0d exp=0", stall_cycles); end
    checks++; if (alloc_count !== 32'd0) begin failures++; $display("FAIL mid_count0 got=%0d exp=0", alloc_count); end
`endif
    shootdown = 1'b1; shootdown_tag = 2'd0; alloc_req = 2'd2;
    repeat (3) tick();
    clear_inputs(); #1;
    checks++; if (num_free !== 7'd32) begin failures++; $display("FAIL mid_denied_nf got=%0d exp=32", num_free); end
`ifdef PREG_ALLOC_STATS_EN
    checks++; if (stall_cycles !== 32'd3) begin failures++; $display("FAIL mid_stall3 got=%0d exp=3", stall_cycles); end
    checks++; if (alloc_count !== 32'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", alloc_count); end
`endif
  endtask

  task automatic test_random();
    int owed, alloc_tot, stall_tot, req, nfree, idx;
    logic [PW-1:0] fp [2];
    logic exp_grant;
    do_reset();
    exp_q.delete(); pool.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(PW'(32 + i));
      pool.push_back(PW'(i));
    end
    owed = 0; alloc_tot = 0; stall_tot = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req = $urandom_range(0, 2);
      if (((cyc / 100) % 2) == 0) nfree = ($urandom_range(0, 3) == 0) ? 1 : 0;
      else nfree = $urandom_range(0, 2);
      if (nfree > owed) nfree = owed;
      for (int k = 0; k < nfree; k++) begin
        idx = $urandom_range(0, pool.size() - 1);
        fp[k] = pool[idx];
        pool.delete(idx);
      end
      alloc_req = 2'(req);
      free_valid_1 = (nfree >= 1); free_preg_1 = (nfree >= 1) ? fp[0] : '0;
      free_valid_2 = (nfree >= 2); free_preg_2 = (nfree >= 2) ? fp[1] : '0;
      ckpt_valid = $urandom_range(0, 1); ckpt_tag = 2'($urandom_range(0, 3));
      #1;
      exp_grant = (req <= exp_q.size());
      checks++; if (alloc_grant !== exp_grant) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", cyc, alloc_grant, exp_grant); end
      checks++; if (num_free !== 7'(exp_q.size())) begin failures++; $display("FAIL rnd_nf cyc=%0d got=%0d exp=%0d", cyc, num_free, exp_q.size()); end
      if (exp_q.size() >= 1) begin
        checks++; if (preg1 !== exp_q[0]) begin failures++; $display("FAIL rnd_preg1 cyc=%0d got=%0d exp=%0d", cyc, preg1, exp_q[0]); end
      end
      if (exp_q.size() >= 2) begin
        checks++; if (preg2 !== exp_q[1]) begin failures++; $display("FAIL rnd_preg2 cyc=%0d got=%0d exp=%0d", cyc, preg2, exp_q[1]); end
      end
      if (exp_grant) begin
        for (int k = 0; k < req; k++) pool.push_back(exp_q.pop_front());
        owed += req; alloc_tot += req;
      end else begin
        stall_tot++;
      end
      for (int k = 0; k < nfree; k++) exp_q.push_back(fp[k]);
      owed -= nfree;
      tick();
    end
    clear_inputs(); #1;
    checks++; if (num_free !== 7'(exp_q.size())) begin failures++; $display("FAIL rnd_final_nf got=%0d exp=%0d", num_free, exp_q.size()); end
`ifdef PREG_ALLOC_STATS_EN
    checks++; if (alloc_count !== 32'(alloc_tot)) begin failures++; $display("FAIL rnd_alloc_count got=%0d exp=%0d", alloc_count, alloc_tot); end
    checks++; if (stall_cycles !== 32'(stall_tot)) begin failures++; $display("FAIL rnd_stall got=%0d exp=%0d", stall_cycles, stall_tot); end
`endif
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_empty_free();
    test_ckpt_shootdown();
    test_shootdown_free();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
